// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the ID/EX operand stage.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;

    typedef enum logic {
        A_SEL_RS1 = 1'b0,
        A_SEL_PC  = 1'b1
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

    // Immediate-form ops carry no real funct7; only shifts encode one, in imm[11:5].
    function automatic logic [6:0] alu_safe_funct7(
        input b_sel_e     b_sel,
        input logic [2:0] funct3,
        input logic [6:0] funct7,
        input logic [6:0] imm_11_5
    );
        logic [6:0] f7;
        f7 = funct7;
        if (b_sel == B_SEL_IMM) begin
            f7 = (funct3 == FUNCT3_SR) ? imm_11_5 : FUNCT7_BASE;
        end
        return f7;
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, hazard-side and ALU-side signals of the ID/EX operand stage.
interface id_ex_operand_stage_if #(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [2:0]            id_funct3;
    logic [6:0]            id_funct7;
    logic                  id_a_sel;
    logic                  id_b_sel;
    logic                  id_rd_we;
    logic [REG_ADDR_W-1:0] exm_rd_addr;
    logic                  exm_rd_we;
    logic [XLEN-1:0]       exm_result;
    logic [REG_ADDR_W-1:0] mwb_rd_addr;
    logic                  mwb_rd_we;
    logic [XLEN-1:0]       mwb_data;
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;
    logic [2:0]            alu_funct3;
    logic [6:0]            alu_funct7;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_rd_we;
    logic [XLEN-1:0]       ex_store_data;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_funct3, id_funct7,
               id_a_sel, id_b_sel, id_rd_we,
               exm_rd_addr, exm_rd_we, exm_result, mwb_rd_addr, mwb_rd_we, mwb_data,
        input  alu_a, alu_b, alu_funct3, alu_funct7, ex_valid, ex_rd_addr,
               ex_rd_we, ex_store_data
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_funct3, id_funct7,
               id_a_sel, id_b_sel, id_rd_we,
               exm_rd_addr, exm_rd_we, exm_result, mwb_rd_addr, mwb_rd_we, mwb_data,
        output alu_a, alu_b, alu_funct3, alu_funct7, ex_valid, ex_rd_addr,
               ex_rd_we, ex_store_data
    );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-source forwarding mux: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_mux #(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  exm_rd_we,
    input  logic [REG_ADDR_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]       exm_result,
    input  logic                  mwb_rd_we,
    input  logic [REG_ADDR_W-1:0] mwb_rd_addr,
    input  logic [XLEN-1:0]       mwb_data,
    input  logic [XLEN-1:0]       reg_data,
    output logic [XLEN-1:0]       fwd_data
);
    // Pick the youngest in-flight producer of src, else the register-file value.
    always_comb begin
        fwd_data = reg_data;
        if (src_addr != '0) begin
            if (exm_rd_we && (exm_rd_addr == src_addr)) begin
                fwd_data = exm_result;
            end else if (mwb_rd_we && (mwb_rd_addr == src_addr)) begin
                fwd_data = mwb_data;
            end
        end
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding feeding the ALU.
module id_ex_operand_stage #(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);
    import riscv_pkg::*;

    logic                  valid_q,    valid_d;
    logic [XLEN-1:0]       pc_q,       pc_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]       imm_q,      imm_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic [2:0]            funct3_q,   funct3_d;
    logic [6:0]            funct7_q,   funct7_d;
    a_sel_e                a_sel_q,    a_sel_d;
    b_sel_e                b_sel_q,    b_sel_d;
    logic                  rd_we_q,    rd_we_d;

    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;

    // Next register contents: flush beats stall beats normal capture.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        rd_we_d    = rd_we_q;
        if (bus.flush) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            funct3_d   = '0;
            funct7_d   = '0;
            a_sel_d    = A_SEL_RS1;
            b_sel_d    = B_SEL_RS2;
            rd_we_d    = 1'b0;
        end else if (!bus.stall) begin
            valid_d    = bus.id_valid;
            pc_d       = bus.id_pc;
            rs1_data_d = bus.id_rs1_data;
            rs2_data_d = bus.id_rs2_data;
            imm_d      = bus.id_imm;
            rs1_addr_d = bus.id_rs1_addr;
            rs2_addr_d = bus.id_rs2_addr;
            rd_addr_d  = bus.id_rd_addr;
            funct3_d   = bus.id_funct3;
            funct7_d   = alu_safe_funct7(b_sel_e'(bus.id_b_sel), bus.id_funct3,
                                         bus.id_funct7, bus.id_imm[11:5]);
            a_sel_d    = a_sel_e'(bus.id_a_sel);
            b_sel_d    = b_sel_e'(bus.id_b_sel);
            rd_we_d    = bus.id_rd_we;
        end
    end

    // ID/EX register bank with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            a_sel_q    <= A_SEL_RS1;
            b_sel_q    <= B_SEL_RS2;
            rd_we_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            rd_we_q    <= rd_we_d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .src_addr    (rs1_addr_q),
        .exm_rd_we   (bus.exm_rd_we),
        .exm_rd_addr (bus.exm_rd_addr),
        .exm_result  (bus.exm_result),
        .mwb_rd_we   (bus.mwb_rd_we),
        .mwb_rd_addr (bus.mwb_rd_addr),
        .mwb_data    (bus.mwb_data),
        .reg_data    (rs1_data_q),
        .fwd_data    (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .src_addr    (rs2_addr_q),
        .exm_rd_we   (bus.exm_rd_we),
        .exm_rd_addr (bus.exm_rd_addr),
        .exm_result  (bus.exm_result),
        .mwb_rd_we   (bus.mwb_rd_we),
        .mwb_rd_addr (bus.mwb_rd_addr),
        .mwb_data    (bus.mwb_data),
        .reg_data    (rs2_data_q),
        .fwd_data    (fwd_rs2)
    );

    // Operand selection and output qualification stay combinational after the register.
    always_comb begin
        bus.alu_a         = (a_sel_q == A_SEL_PC)  ? pc_q  : fwd_rs1;
        bus.alu_b         = (b_sel_q == B_SEL_IMM) ? imm_q : fwd_rs2;
        bus.alu_funct3    = funct3_q;
        bus.alu_funct7    = funct7_q;
        bus.ex_valid      = valid_q;
        bus.ex_rd_addr    = rd_addr_q;
        bus.ex_rd_we      = rd_we_q & valid_q;
        bus.ex_store_data = fwd_rs2;
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding, sanitising, stall/flush, reset.
module tb_id_ex_operand_stage;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    id_ex_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

    id_ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(
        input logic        valid,
        input logic [31:0] pc,
        input logic [4:0]  rs1_a,
        input logic [31:0] rs1_d,
        input logic [4:0]  rs2_a,
        input logic [31:0] rs2_d,
        input logic [31:0] imm,
        input logic [4:0]  rd,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic        a_sel,
        input logic        b_sel,
        input logic        rd_we
    );
        bus.id_valid    = valid;
        bus.id_pc       = pc;
        bus.id_rs1_addr = rs1_a;
        bus.id_rs1_data = rs1_d;
        bus.id_rs2_addr = rs2_a;
        bus.id_rs2_data = rs2_d;
        bus.id_imm      = imm;
        bus.id_rd_addr  = rd;
        bus.id_funct3   = f3;
        bus.id_funct7   = f7;
        bus.id_a_sel    = a_sel;
        bus.id_b_sel    = b_sel;
        bus.id_rd_we    = rd_we;
    endtask

    task automatic drive_hz(
        input logic        exm_we, input logic [4:0] exm_a, input logic [31:0] exm_r,
        input logic        mwb_we, input logic [4:0] mwb_a, input logic [31:0] mwb_d
    );
        bus.exm_rd_we   = exm_we;
        bus.exm_rd_addr = exm_a;
        bus.exm_result  = exm_r;
        bus.mwb_rd_we   = mwb_we;
        bus.mwb_rd_addr = mwb_a;
        bus.mwb_data    = mwb_d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst       = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        drive_hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset state
        #12;
        check("rst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("rst_ex_rd_we", {31'b0, bus.ex_rd_we}, 32'h0);
        check("rst_alu_a", bus.alu_a, 32'h0);
        check("rst_alu_b", bus.alu_b, 32'h0);
        check("rst_alu_funct7", {25'b0, bus.alu_funct7}, 32'h0);
        rst = 1'b0;

        // ADD x3,x1,x2 with no hazards
        drive_id(1'b1, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("add_alu_a", bus.alu_a, 32'd5);
        check("add_alu_b", bus.alu_b, 32'd7);
        check("add_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
        check("add_ex_rd_we", {31'b0, bus.ex_rd_we}, 32'h1);
        check("add_ex_rd_addr", {27'b0, bus.ex_rd_addr}, 32'd3);

        // EX/MEM forward onto rs1
        drive_hz(1'b1, 5'd1, 32'd100, 1'b0, 5'd0, 32'h0);
        #1;
        check("exm_fwd_alu_a", bus.alu_a, 32'd100);
        check("exm_fwd_alu_b", bus.alu_b, 32'd7);

        // MEM/WB forward onto rs1
        drive_hz(1'b0, 5'd1, 32'd100, 1'b1, 5'd1, 32'd55);
        #1;
        check("mwb_fwd_alu_a", bus.alu_a, 32'd55);

        // Double hazard on x2: EX/MEM wins
        drive_hz(1'b1, 5'd2, 32'd200, 1'b1, 5'd2, 32'd300);
        #1;
        check("dbl_alu_b", bus.alu_b, 32'd200);
        check("dbl_store", bus.ex_store_data, 32'd200);

        // Address match without write enable: no forward
        drive_hz(1'b0, 5'd2, 32'd200, 1'b0, 5'd2, 32'd300);
        #1;
        check("nowe_alu_b", bus.alu_b, 32'd7);

        // Same double hazard targeting x0: never forwarded
        drive_id(1'b1, 32'h44, 5'd1, 32'd5, 5'd0, 32'd0, 32'h0, 5'd3, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive_hz(1'b1, 5'd0, 32'd200, 1'b1, 5'd0, 32'd300);
        #1;
        check("x0_alu_b", bus.alu_b, 32'd0);
        check("x0_store", bus.ex_store_data, 32'd0);
        drive_hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // ADDI x6,x5,12 with stray funct7=0100000
        drive_id(1'b1, 32'h48, 5'd5, 32'd34, 5'd12, 32'h0, 32'd12, 5'd6, 3'b000, 7'b0100000, 1'b0, 1'b1, 1'b1);
        tick();
        check("addi_funct7", {25'b0, bus.alu_funct7}, 32'h0);
        check("addi_alu_b", bus.alu_b, 32'd12);
        check("addi_sum", bus.alu_a + bus.alu_b, 32'd46);

        // SRAI: funct7 from imm[11:5]
        drive_id(1'b1, 32'h4c, 5'd5, 32'd34, 5'd5, 32'h0, 32'h405, 5'd6, 3'b101, 7'b0000000, 1'b0, 1'b1, 1'b1);
        tick();
        check("srai_funct7", {25'b0, bus.alu_funct7}, 32'h20);
        check("srai_funct3", {29'b0, bus.alu_funct3}, 32'h5);

        // SRLI with stray funct7 input: still imm[11:5]
        drive_id(1'b1, 32'h50, 5'd5, 32'd34, 5'd5, 32'h0, 32'h005, 5'd6, 3'b101, 7'b0100000, 1'b0, 1'b1, 1'b1);
        tick();
        check("srli_funct7", {25'b0, bus.alu_funct7}, 32'h0);

        // R-type SUB: funct7 passes through
        drive_id(1'b1, 32'h54, 5'd1, 32'd9, 5'd2, 32'd4, 32'h0, 5'd3, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b1);
        tick();
        check("sub_funct7", {25'b0, bus.alu_funct7}, 32'h20);

        // Stall holds for two cycles while ID changes
        drive_id(1'b1, 32'h80, 5'd8, 32'd11, 5'd9, 32'd22, 32'h0, 5'd7, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        tick();
        bus.stall = 1'b1;
        drive_id(1'b1, 32'h84, 5'd10, 32'd99, 5'd11, 32'd88, 32'h0, 5'd12, 3'd4, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("stall_alu_a", bus.alu_a, 32'd11);
        check("stall_alu_b", bus.alu_b, 32'd22);
        check("stall_rd_addr", {27'b0, bus.ex_rd_addr}, 32'd7);
        check("stall_rd_we", {31'b0, bus.ex_rd_we}, 32'h1);

        // Held instruction picks up a fresh forward
        drive_hz(1'b1, 5'd8, 32'h77, 1'b0, 5'd0, 32'h0);
        #1;
        check("stall_fwd_alu_a", bus.alu_a, 32'h77);

        // Flush wins over stall
        bus.flush = 1'b1;
        tick();
        check("flush_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("flush_ex_rd_we", {31'b0, bus.ex_rd_we}, 32'h0);
        check("flush_alu_a", bus.alu_a, 32'h0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        drive_hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Bubble masks a stored rd_we
        drive_id(1'b0, 32'h90, 5'd1, 32'd1, 5'd2, 32'd2, 32'h0, 5'd4, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("bubble_rd_we", {31'b0, bus.ex_rd_we}, 32'h0);
        check("bubble_rd_addr", {27'b0, bus.ex_rd_addr}, 32'd4);

        // AUIPC: PC and imm, rs1 forward ignored
        drive_id(1'b1, 32'h1000, 5'd1, 32'd5, 5'd0, 32'd0, 32'h2000, 5'd9, 3'd0, 7'd0, 1'b1, 1'b1, 1'b1);
        tick();
        drive_hz(1'b1, 5'd1, 32'hdead, 1'b0, 5'd0, 32'h0);
        #1;
        check("auipc_alu_a", bus.alu_a, 32'h1000);
        check("auipc_alu_b", bus.alu_b, 32'h2000);

        // Asynchronous reset between edges
        rst = 1'b1;
        #1;
        check("arst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("arst_alu_a", bus.alu_a, 32'h0);
        check("arst_alu_b", bus.alu_b, 32'h0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
